// File: rtl/game_controller.sv
// Breakout game sequencer: attract -> serve -> play -> miss/over/win flow,
// ball motion gating, serve/field-reload strobes, lives and score keeping.
module game_controller #(
  parameter int LIVES        = 3,
  parameter int NUM_BLOCKS   = 65,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int SCORE_W      = 10
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               en,
  input  logic               frame_pulse,
  input  logic               btn_select,
  input  logic               ball_lost,
  input  logic               block_hit,
  output logic               do_move,
  output logic               serve,
  output logic               blocks_reset,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_ATTRACT = 3'd0,
    S_SERVE   = 3'd1,
    S_PLAY    = 3'd2,
    S_MISS    = 3'd3,
    S_OVER    = 3'd4,
    S_WIN     = 3'd5
  } state_t;

  localparam int TMAX    = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam int HIT_W   = $clog2(NUM_BLOCKS + 1);
  localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_FRAMES - 1);
  localparam logic [TIMER_W-1:0] MISS_LAST  = TIMER_W'(MISS_FRAMES - 1);
  localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(NUM_BLOCKS - 1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

  logic               r_sync1, r_sync2, r_sync3;
  logic               w_sel_edge;
  state_t             r_state, w_next_state;
  logic [TIMER_W-1:0] r_timer, w_next_timer;
  logic [2:0]         r_lives, w_next_lives;
  logic [SCORE_W-1:0] r_score, w_next_score;
  logic [HIT_W-1:0]   r_hit_cnt, w_next_hit_cnt;
  logic               r_do_move, r_serve, r_blocks_reset;
  logic               w_next_serve, w_next_blocks_reset;

  // Button synchroniser runs regardless of en, so edges seen while frozen are lost.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= btn_select;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_sel_edge = r_sync2 & ~r_sync3;

  always_comb begin
    w_next_state        = r_state;
    w_next_timer        = r_timer;
    w_next_lives        = r_lives;
    w_next_score        = r_score;
    w_next_hit_cnt      = r_hit_cnt;
    w_next_serve        = 1'b0;
    w_next_blocks_reset = 1'b0;
    case (r_state)
      S_ATTRACT: begin
        if (w_sel_edge) begin
          w_next_state        = S_SERVE;
          w_next_lives        = LIVES_INIT;
          w_next_score        = '0;
          w_next_hit_cnt      = '0;
          w_next_timer        = '0;
          w_next_serve        = 1'b1;
          w_next_blocks_reset = 1'b1;
        end
      end
      S_SERVE: begin
        if (frame_pulse) begin
          if (r_timer == SERVE_LAST) begin
            w_next_state = S_PLAY;
            w_next_timer = '0;
          end else begin
            w_next_timer = r_timer + TIMER_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (block_hit) begin
          if (r_score != '1) w_next_score = r_score + SCORE_W'(1);
          w_next_hit_cnt = r_hit_cnt + HIT_W'(1);
        end
        // A hit that clears the field wins even if the ball is lost on the same cycle.
        if (block_hit && (r_hit_cnt == HIT_LAST)) begin
          w_next_state = S_WIN;
        end else if (ball_lost) begin
          w_next_lives = r_lives - 3'd1;
          w_next_timer = '0;
          w_next_state = S_MISS;
        end
      end
      S_MISS: begin
        if (frame_pulse) begin
          if (r_timer == MISS_LAST) begin
            w_next_timer = '0;
            if (r_lives == 3'd0) begin
              w_next_state = S_OVER;
            end else begin
              w_next_serve = 1'b1;
              w_next_state = S_SERVE;
            end
          end else begin
            w_next_timer = r_timer + TIMER_W'(1);
          end
        end
      end
      S_OVER, S_WIN: begin
        if (w_sel_edge) w_next_state = S_ATTRACT;
      end
      default: w_next_state = S_ATTRACT;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state        <= S_ATTRACT;
      r_timer        <= '0;
      r_lives        <= LIVES_INIT;
      r_score        <= '0;
      r_hit_cnt      <= '0;
      r_do_move      <= 1'b0;
      r_serve        <= 1'b0;
      r_blocks_reset <= 1'b0;
    end else if (en) begin
      r_state        <= w_next_state;
      r_timer        <= w_next_timer;
      r_lives        <= w_next_lives;
      r_score        <= w_next_score;
      r_hit_cnt      <= w_next_hit_cnt;
      r_do_move      <= (w_next_state == S_PLAY);
      r_serve        <= w_next_serve;
      r_blocks_reset <= w_next_blocks_reset;
    end else begin
      r_serve        <= 1'b0;
      r_blocks_reset <= 1'b0;
    end
  end

  assign do_move      = r_do_move;
  assign serve        = r_serve;
  assign blocks_reset = r_blocks_reset;
  assign lives        = r_lives;
  assign score        = r_score;
  assign state        = r_state;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed game scenarios plus a random
// soak, all compared each cycle against a frame-countdown model of the game rules.
module tb_game_controller;

  localparam int LIVES        = 3;
  localparam int NUM_BLOCKS   = 65;
  localparam int SERVE_FRAMES = 60;
  localparam int MISS_FRAMES  = 90;
  localparam int SCORE_W      = 10;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

  logic               clk;
  logic               nRst;
  logic               en;
  logic               frame_pulse;
  logic               btn_select;
  logic               ball_lost;
  logic               block_hit;
  logic               do_move;
  logic               serve;
  logic               blocks_reset;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [2:0]         state;

  game_controller #(
    .LIVES(LIVES), .NUM_BLOCKS(NUM_BLOCKS), .SERVE_FRAMES(SERVE_FRAMES),
    .MISS_FRAMES(MISS_FRAMES), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .nRst(nRst), .en(en), .frame_pulse(frame_pulse),
    .btn_select(btn_select), .ball_lost(ball_lost), .block_hit(block_hit),
    .do_move(do_move), .serve(serve), .blocks_reset(blocks_reset),
    .lives(lives), .score(score), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int serveCnt = 0;
  int resetCnt = 0;

  // Game model: phase codes are the published debug codes; waits count frames down.
  int mPhase, mLives, mScore, mHits, mFramesLeft;
  bit mServe, mBlocksReset;
  bit mBtn [4];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mLives = LIVES; mScore = 0; mHits = 0; mFramesLeft = 0;
    mServe = 0; mBlocksReset = 0;
    for (int i = 0; i < 4; i++) mBtn[i] = 0;
  endtask

  task automatic modelStep();
    bit sel;
    mBtn[3] = mBtn[2]; mBtn[2] = mBtn[1]; mBtn[1] = mBtn[0]; mBtn[0] = btn_select;
    sel = mBtn[2] && !mBtn[3];
    mServe = 0;
    mBlocksReset = 0;
    if (en) begin
      case (mPhase)
        0: if (sel) begin
          mPhase = 1; mLives = LIVES; mScore = 0; mHits = 0;
          mFramesLeft = SERVE_FRAMES; mServe = 1; mBlocksReset = 1;
        end
        1: if (frame_pulse) begin
          mFramesLeft--;
          if (mFramesLeft == 0) mPhase = 2;
        end
        2: begin
          if (block_hit) begin
            if (mScore < SCORE_MAX) mScore++;
            mHits++;
          end
          if (mHits == NUM_BLOCKS) mPhase = 5;
          else if (ball_lost) begin
            mLives--; mFramesLeft = MISS_FRAMES; mPhase = 3;
          end
        end
        3: if (frame_pulse) begin
          mFramesLeft--;
          if (mFramesLeft == 0) begin
            if (mLives == 0) mPhase = 4;
            else begin
              mPhase = 1; mFramesLeft = SERVE_FRAMES; mServe = 1;
            end
          end
        end
        default: if (sel) mPhase = 0;
      endcase
    end
  endtask

  task automatic checkOutput();
    checkVal("cyc_state", 32'(state), 32'(mPhase));
    checkVal("cyc_do_move", 32'(do_move), 32'(mPhase == 2));
    checkVal("cyc_serve", 32'(serve), 32'(mServe));
    checkVal("cyc_blocks_reset", 32'(blocks_reset), 32'(mBlocksReset));
    checkVal("cyc_lives", 32'(lives), 32'(mLives));
    checkVal("cyc_score", 32'(score), 32'(mScore));
  endtask

  // Called at a falling edge: drive, clock, advance model, check at the next falling edge.
  task automatic applyStimulus(input bit e, input bit f, input bit b, input bit hit, input bit lost);
    en = e; frame_pulse = f; btn_select = b; block_hit = hit; ball_lost = lost;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
    if (serve === 1'b1) serveCnt++;
    if (blocks_reset === 1'b1) resetCnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
    end
  endtask

  task automatic pressSelect();
    applyStimulus(1, 0, 1, 0, 0);
    idle(4);
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_state"}, 32'(state), 0);
    checkVal({tag, "_do_move"}, 32'(do_move), 0);
    checkVal({tag, "_serve"}, 32'(serve), 0);
    checkVal({tag, "_blocks_reset"}, 32'(blocks_reset), 0);
    checkVal({tag, "_lives"}, 32'(lives), LIVES);
    checkVal({tag, "_score"}, 32'(score), 0);
  endtask

  initial begin
    bit btnLvl;
    nRst = 1'b0; en = 1'b1; frame_pulse = 1'b0; btn_select = 1'b0;
    block_hit = 1'b0; ball_lost = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkResetValues("reset");
    nRst = 1'b1;

    $display("[TB] step 1: select held 5 cycles starts a game");
    idle(2);
    serveCnt = 0; resetCnt = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 0, 0);
    idle(4);
    checkVal("t1_state", 32'(state), 1);
    checkVal("t1_lives", 32'(lives), 3);
    checkVal("t1_score", 32'(score), 0);
    checkVal("t1_serve_pulses", serveCnt, 1);
    checkVal("t1_blocks_reset_pulses", resetCnt, 1);

    $display("[TB] step 2: serve hold of 60 frames");
    frames(59);
    checkVal("t2_state_59", 32'(state), 1);
    applyStimulus(1, 1, 0, 0, 0);
    checkVal("t2_state_60", 32'(state), 2);
    checkVal("t2_do_move_60", 32'(do_move), 1);
    idle(3);

    $display("[TB] step 3: three lost balls end the game");
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, 0, 0, 0, 1);
      checkVal("t3_lives", 32'(lives), 32'(3 - k));
      checkVal("t3_state_miss", 32'(state), 3);
      checkVal("t3_do_move_miss", 32'(do_move), 0);
      serveCnt = 0;
      frames(MISS_FRAMES);
      if (k < 3) begin
        checkVal("t3_state_reserve", 32'(state), 1);
        checkVal("t3_reserve_pulses", serveCnt, 1);
        frames(SERVE_FRAMES);
        checkVal("t3_state_play", 32'(state), 2);
      end else begin
        checkVal("t3_state_over", 32'(state), 4);
        checkVal("t3_over_serve_pulses", serveCnt, 0);
      end
    end
    applyStimulus(1, 0, 0, 1, 1);
    checkVal("t3_over_ignores_hits", 32'(score), 0);
    pressSelect();
    checkVal("t3_state_attract", 32'(state), 0);

    $display("[TB] step 4: clearing the field wins");
    pressSelect();
    frames(SERVE_FRAMES);
    for (int i = 0; i < NUM_BLOCKS; i++) applyStimulus(1, 0, 0, 1, 0);
    checkVal("t4_score", 32'(score), 65);
    checkVal("t4_state", 32'(state), 5);
    checkVal("t4_do_move", 32'(do_move), 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkVal("t4_score_after_extra", 32'(score), 65);
    pressSelect();

    $display("[TB] step 5: last hit and lost ball together");
    pressSelect();
    frames(SERVE_FRAMES);
    for (int i = 0; i < NUM_BLOCKS - 1; i++) applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1);
    checkVal("t5_state", 32'(state), 5);
    checkVal("t5_lives", 32'(lives), 3);
    pressSelect();

    $display("[TB] step 6: enable freeze and reset mid-play");
    pressSelect();
    frames(10);
    serveCnt = 0;
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0);
    checkVal("t6_state_frozen", 32'(state), 1);
    frames(SERVE_FRAMES - 11);
    checkVal("t6_state_held_timer", 32'(state), 1);
    frames(1);
    checkVal("t6_state_play", 32'(state), 2);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 0);
    nRst = 1'b0;
    #1;
    modelReset();
    checkResetValues("t6_reset");
    @(negedge clk);
    nRst = 1'b1;
    idle(3);

    $display("[TB] step 7: random soak");
    btnLvl = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 29) == 0) btnLvl = ~btnLvl;
      applyStimulus($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), btnLvl,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
